// File: rtl/dif_ctrl_pkg.sv
// Shared types and constants for the differentiator controller.
package dif_ctrl_pkg;
   localparam int DATA_W      = 13;
   localparam int WARMUP      = 3;
   localparam int FLUSH_LEN   = 3;
   localparam int DEF_TIMEOUT = 15;
   localparam int DEF_HOLDOFF = 8;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      RUN,
      FIRE,
      WAIT,
      ERR
   } state_t;
endpackage

// File: rtl/dif_ctrl_evt.sv
// Event detector: 14-bit magnitude of the third difference, threshold compare
// and holdoff suppression of events following an accepted one.
module dif_ctrl_evt
   import dif_ctrl_pkg::*;
#(
   parameter int HOLDOFF = DEF_HOLDOFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     take,
   input  logic signed [DATA_W-1:0] third,
   input  logic        [DATA_W-1:0] thresh,
   output logic                     event_pulse
);
   localparam int HW = $clog2(HOLDOFF + 1);

   logic signed [DATA_W:0] ext;
   logic        [DATA_W:0] mag;
   logic                   hit;
   logic        [HW-1:0]   hold;

   // One extra bit so that |-4096| is representable.
   always_comb begin
      ext = {third[DATA_W-1], third};
      mag = ext[DATA_W] ? $unsigned(-ext) : $unsigned(ext);
      hit = (mag >= {1'b0, thresh});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold        <= '0;
         event_pulse <= 1'b0;
      end else begin
         event_pulse <= 1'b0;
         if (clr) begin
            hold <= '0;
         end else if (take) begin
            if (hold == '0) begin
               if (hit) begin
                  hold        <= HW'(HOLDOFF);
                  event_pulse <= 1'b1;
               end
            end else begin
               hold <= hold - 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/dif_ctrl.sv
// Differentiator sequencer: flush, sample issue, completion wait with timeout,
// warm-up masking and result registration.
module dif_ctrl
   import dif_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int HOLDOFF = DEF_HOLDOFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] sample_data,
   input  logic        [DATA_W-1:0] thresh,
   output logic                     en_dif,
   output logic signed [DATA_W-1:0] dif_data,
   input  logic                     dif_finish,
   input  logic signed [DATA_W-1:0] third_in,
   output logic                     result_valid,
   output logic signed [DATA_W-1:0] result_third,
   output logic                     event_pulse,
   output logic                     busy,
   output logic                     sample_drop,
   output logic                     err_timeout
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state, nxt;
   logic [1:0]    flush_cnt;
   logic [1:0]    warm;
   logic [TW-1:0] wait_cnt;
   logic          stop_seen;
   logic          accept, take, flush_done, timed_out, done;

   always_comb begin
      accept     = (state == RUN) && sample_valid && !stop && !stop_seen;
      flush_done = (state == FLUSH) && (flush_cnt == 2'(FLUSH_LEN - 1));
      done       = (state == WAIT) && dif_finish;
      timed_out  = (state == WAIT) && !dif_finish && (wait_cnt == TW'(TIMEOUT - 1));
      take       = done && (warm == 2'(WARMUP));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (start && !stop) nxt = FLUSH;
         FLUSH: if (flush_done) nxt = RUN;
         RUN: begin
            if (stop || stop_seen) nxt = IDLE;
            else if (sample_valid) nxt = FIRE;
         end
         FIRE:  nxt = WAIT;
         WAIT: begin
            if (dif_finish) nxt = (stop || stop_seen) ? IDLE : RUN;
            else if (timed_out) nxt = ERR;
         end
         ERR:   if (start) nxt = FLUSH;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      en_dif = (state == FLUSH) || (state == FIRE);
      busy   = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dif_data     <= '0;
         flush_cnt    <= '0;
         warm         <= '0;
         wait_cnt     <= '0;
         stop_seen    <= 1'b0;
         result_valid <= 1'b0;
         result_third <= '0;
         sample_drop  <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         sample_drop  <= sample_valid && !accept;
         result_valid <= take;
         if (take) result_third <= third_in;

         if (nxt == FLUSH && state != FLUSH) begin
            dif_data  <= '0;
            flush_cnt <= '0;
         end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + 2'd1;
         end
         if (accept) dif_data <= sample_data;

         if (flush_done)                          warm <= '0;
         else if (done && warm != 2'(WARMUP))     warm <= warm + 2'd1;

         if (state == FIRE)      wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

         // Stop is remembered while an operation is in flight and honoured at the next RUN/WAIT exit.
         if (state == IDLE || state == RUN || state == ERR) stop_seen <= 1'b0;
         else if (stop)                                     stop_seen <= 1'b1;

         if (timed_out)                   err_timeout <= 1'b1;
         else if (state == ERR && start)  err_timeout <= 1'b0;
      end
   end

   dif_ctrl_evt #(.HOLDOFF(HOLDOFF)) u_evt (
      .clk         (clk),
      .rst         (rst),
      .clr         (flush_done),
      .take        (take),
      .third       (third_in),
      .thresh      (thresh),
      .event_pulse (event_pulse)
   );
endmodule

// File: doc/dif_ctrl.md
DIF_CTRL -- requirements
Module: dif_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent waiting for dif_finish.
REQ-002 Parameter HOLDOFF, default 8: number of accepted results after an event during which further events are suppressed.
REQ-003 Port clk, in, 1: the single clock; all logic on its rising edge.
REQ-004 Port rst, in, 1: synchronous, active-high reset.
REQ-005 Port start, in, 1: level-sampled; begins a run (flush, then acquisition).
REQ-006 Port stop, in, 1: ends the run after any in-flight operation.
REQ-007 Port sample_valid, in, 1: sample_data is valid this cycle.
REQ-008 Port sample_data, in, 13, signed: raw sample.
REQ-009 Port thresh, in, 13, unsigned: event magnitude threshold.
REQ-010 Port en_dif, out, 1: enable to the differentiator.
REQ-011 Port dif_data, out, 13, signed: current_data to the differentiator.
REQ-012 Port dif_finish, in, 1: differentiator done flag.
REQ-013 Port third_in, in, 13, signed: differentiator third-difference output.
REQ-014 Port result_valid, out, 1: one-cycle pulse qualifying result_third.
REQ-015 Port result_third, out, 13, signed: registered accepted third difference.
REQ-016 Port event_pulse, out, 1: one-cycle threshold event.
REQ-017 Port busy, out, 1: high in any state except IDLE.
REQ-018 Port sample_drop, out, 1: one-cycle pulse when a sample is discarded.
REQ-019 Port err_timeout, out, 1: sticky timeout error flag.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, FLUSH, RUN, FIRE, WAIT and ERR.
REQ-021 In IDLE, start=1 with stop=0 SHALL go to FLUSH; stop SHALL win when start and stop are asserted together.
REQ-022 FLUSH SHALL assert en_dif=1 with dif_data=0 for exactly 3 consecutive cycles, then enter RUN, clearing the warm-up counter and the holdoff counter.
REQ-023 In RUN, sample_valid=1 SHALL latch sample_data into dif_data and enter FIRE; if stop=1 in that same cycle, RUN SHALL instead go to IDLE and the sample SHALL be dropped.
REQ-024 FIRE SHALL last 1 cycle with en_dif=1, then enter WAIT.
REQ-025 en_dif SHALL be 0 in all states other than FLUSH and FIRE.
REQ-026 WAIT SHALL count cycles.
REQ-027 In WAIT, dif_finish=1 SHALL return to RUN, or to IDLE if stop was seen at any point since FIRE.
REQ-028 If TIMEOUT cycles elapse in WAIT without dif_finish, the FSM SHALL enter ERR and set err_timeout.
REQ-029 In ERR, start=1 SHALL clear err_timeout and enter FLUSH; all other inputs SHALL be ignored.
REQ-030 sample_valid in any state other than RUN (including IDLE) SHALL pulse sample_drop the following cycle; no data SHALL be latched.
REQ-031 Latency: sample_valid at cycle n (in RUN) -> en_dif at n+1 -> dif_finish expected at n+2 -> result_valid/event_pulse at n+3.
REQ-032 Maximum throughput SHALL be one sample per 3 cycles.
REQ-033 The first 3 dif_finish completions after FLUSH SHALL only increment the warm-up counter (saturating at 3) and SHALL produce no result_valid.
REQ-034 Each later completion SHALL pulse result_valid and register third_in into result_third.
REQ-035 The magnitude SHALL be computed in 14 bits: |-4096| = 4096.
REQ-036 The comparison SHALL be unsigned 14-bit magnitude >= zero-extended thresh.
REQ-037 event_pulse SHALL assert with result_valid when the magnitude >= thresh and the holdoff counter is 0; this SHALL load holdoff with HOLDOFF.
REQ-038 Each result_valid with holdoff > 0 SHALL decrement holdoff.
REQ-039 start while busy and not in ERR SHALL be ignored.
REQ-040 dif_finish arriving outside WAIT SHALL be ignored.

Reset
REQ-041 rst=1 SHALL force IDLE within one cycle, mid-operation included.
REQ-042 On reset, all outputs SHALL be 0 (dif_data=0, result_third=0, err_timeout=0) and the warm-up, holdoff and timeout counters SHALL be 0.
REQ-043 Reset SHALL take precedence over all other inputs.

Structure
REQ-044 Package dif_ctrl_pkg SHALL hold the state enumeration, DATA_W=13, WARMUP=3, FLUSH_LEN=3 and the default TIMEOUT/HOLDOFF values.
REQ-045 Sub-module dif_ctrl_evt SHALL hold the magnitude, compare and holdoff logic; the FSM and counters SHALL stay in dif_ctrl.

Verification
REQ-046 Scenario: rst, then start -> en_dif high for 3 cycles with dif_data=0, busy=1, then RUN.
REQ-047 Scenario: after flush, 5 samples 10,20,40,80,160 with a differentiator model -> no results for the first 3; result_third=10 and 20 on samples 4 and 5; each result_valid exactly 3 cycles after its sample_valid.
REQ-048 Scenario: thresh=50, third values 60,70,60 ... with HOLDOFF=2 -> event on the 1st and 4th results only.
REQ-049 Scenario: third_in=-4096, thresh=4095 -> event_pulse=1.
REQ-050 Scenario: sample_valid asserted in FIRE and WAIT -> sample_drop pulses, dif_data unchanged; stop during WAIT -> IDLE after dif_finish.
REQ-051 Scenario: dif_finish held 0 -> ERR after 15 WAIT cycles with err_timeout=1; sample ignored in ERR; start -> flush restarts and err_timeout clears; rst mid-WAIT -> IDLE with all outputs 0.
